// File: rtl/mux2_stream_arbiter_if.sv
// Handshake bundle for the two-input stream arbiter: channels A and B, mux select, output stage.
// Latency: none (wires only).
// Backpressure: carried by a_ready/b_ready (arbiter to sources) and y_ready (sink to arbiter).
interface mux2_stream_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             sel;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_ready;
  logic             y_src;

  // Arbiter side: consumes A/B and y_ready, produces grants and the output word.
  modport slave (
    input  a_data, a_valid, b_data, b_valid, y_ready,
    output a_ready, b_ready, sel, y_data, y_valid, y_src
  );

  // Environment side: sources on A/B and the sink on Y.
  modport master (
    output a_data, a_valid, b_data, b_valid, y_ready,
    input  a_ready, b_ready, sel, y_data, y_valid, y_src
  );
endinterface

// File: rtl/mux2_stream_arbiter.sv
// Two-input round-robin stream arbiter with bounded bursts, driving the 2:1 mux select and an output DFF stage.
// Latency: 1 cycle from input handshake to y_valid; one word per cycle sustained.
// Backpressure: y_ready low with a word held freezes everything and drops both readies. Macro MUX_ARB_FIXED_PRIO_EN selects fixed A-over-B priority.
module mux2_stream_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mux2_stream_arbiter_if.slave  bus
);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] y_data_q;
  logic             y_valid_q;
  logic             y_src_q;

  logic load_en;
  logic owner;
  logic gnt;
  logic gnt_vld;

  // Grant decision: pure function of current valids, owner, burst count and output stage occupancy.
  always_comb begin
    load_en = !y_valid_q || bus.y_ready;
    owner   = (state == OWN_B);
    gnt     = owner;
`ifdef MUX_ARB_FIXED_PRIO_EN
    // A always wins when present; the burst count is tracked but never consulted.
    gnt = !bus.a_valid && bus.b_valid;
`else
    begin
      logic owner_vld;
      logic other_vld;
      owner_vld = owner ? bus.b_valid : bus.a_valid;
      other_vld = owner ? bus.a_valid : bus.b_valid;
      // Owner keeps the grant until its burst is used up, unless nobody else is asking.
      if (owner_vld && ((cnt < MAX_B) || !other_vld)) begin
        gnt = owner;
      end else if (other_vld) begin
        gnt = !owner;
      end else begin
        gnt = owner;
      end
    end
`endif
    gnt_vld = gnt ? bus.b_valid : bus.a_valid;
  end

  assign bus.sel     = gnt && !rst;
  assign bus.a_ready = load_en && !gnt && !rst;
  assign bus.b_ready = load_en && gnt && !rst;
  assign bus.y_data  = y_data_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_src   = y_src_q;

  // Owner/burst FSM and output register; a pending output word is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OWN_A;
      cnt       <= 4'd0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= 1'b0;
    end else if (load_en) begin
      if (gnt_vld) begin
        y_data_q  <= gnt ? bus.b_data : bus.a_data;
        y_src_q   <= gnt;
        y_valid_q <= 1'b1;
        if (gnt == owner) begin
          cnt <= (cnt >= MAX_B) ? MAX_B : cnt + 4'd1;
        end else begin
          state <= state_t'(gnt);
          cnt   <= 4'd1;
        end
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Self-checking bench: history-based reference model plus directed and random stimulus.
// The model derives the owner and burst length from the list of past transfers.
// The output stage is modelled as a one-deep queue of {src, data}.
module tb_mux2_stream_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux2_stream_arbiter_if #(.WIDTH(W)) bus ();

  mux2_stream_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: sources of past transfers since reset, and the output word queue.
  bit           hist[$];
  logic [W:0]   yq[$];
  // Words the DUT actually delivered (y_valid && y_ready), for directed checks.
  logic [W-1:0] obs_dat[$];
  bit           obs_src[$];

  logic         s_sel, s_ar, s_br, s_yv, s_ys;
  logic [W-1:0] s_yd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Grant from the rules: owner = source of the latest transfer (A if none), burst = trailing run length.
  function automatic bit model_gnt(input bit av, input bit bv);
    bit owner;
    int run;
    bit ov, oth;
    owner = (hist.size() != 0) ? hist[hist.size()-1] : 1'b0;
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != owner) break;
      run++;
    end
    ov  = owner ? bv : av;
    oth = owner ? av : bv;
`ifdef MUX_ARB_FIXED_PRIO_EN
    return av ? 1'b0 : bv;
`else
    if (ov && (run < MB || !oth)) return owner;
    if (oth) return !owner;
    return owner;
`endif
  endfunction

  // One clock cycle: drive, sample mid-cycle, compare against model, advance model.
  task automatic cycle(input bit r, input bit av, input logic [W-1:0] ad,
                       input bit bv, input logic [W-1:0] bd, input bit yr);
    bit g, le, gv;
    rst         = r;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #3;
    s_sel = bus.sel;
    s_ar  = bus.a_ready;
    s_br  = bus.b_ready;
    s_yv  = bus.y_valid;
    s_yd  = bus.y_data;
    s_ys  = bus.y_src;
    le = (yq.size() == 0) || yr;
    g  = model_gnt(av, bv);
    if (r) begin
      chk("sel_in_rst", {31'd0, s_sel}, 0);
      chk("a_ready_in_rst", {31'd0, s_ar}, 0);
      chk("b_ready_in_rst", {31'd0, s_br}, 0);
    end else begin
      chk("sel", {31'd0, s_sel}, {31'd0, g});
      chk("a_ready", {31'd0, s_ar}, {31'd0, le && !g});
      chk("b_ready", {31'd0, s_br}, {31'd0, le && g});
    end
    chk("y_valid", {31'd0, s_yv}, {31'd0, yq.size() != 0});
    if (yq.size() != 0) begin
      chk("y_data", {24'd0, s_yd}, {24'd0, yq[0][W-1:0]});
      chk("y_src", {31'd0, s_ys}, {31'd0, yq[0][W]});
    end
    if (!r && s_yv && yr) begin
      obs_dat.push_back(s_yd);
      obs_src.push_back(s_ys);
    end
    if (r) begin
      yq.delete();
      hist.delete();
    end else if (le) begin
      if (yq.size() != 0) void'(yq.pop_front());
      gv = g ? bv : av;
      if (gv) begin
        yq.push_back({g, g ? bd : ad});
        hist.push_back(g);
        if (hist.size() > 40) void'(hist.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic rst_cycle();
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_src_seq(input string name, input bit exp[$]);
    chk($sformatf("%s_count", name), obs_src.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs_src.size(); i++)
      chk($sformatf("%s_src%0d", name, i), {31'd0, obs_src[i]}, {31'd0, exp[i]});
  endtask

  bit exp_seq[$];

  initial begin
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_data  = '0;
    bus.y_ready = 1'b1;
    rst = 1'b1;
    // Bring DUT registers out of X before checked operation begins.
    @(posedge clk);
    #1;

    // Reset held 2 cycles with both channels valid; first grant after release is A.
    cycle(1'b1, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
    cycle(1'b1, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
    chk("rst_y_valid", {31'd0, s_yv}, 0);
    chk("rst_y_data", {24'd0, s_yd}, 0);
    chk("rst_sel", {31'd0, s_sel}, 0);
    chk("rst_a_ready", {31'd0, s_ar}, 0);
    chk("rst_b_ready", {31'd0, s_br}, 0);
    cycle(1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
    chk("first_grant_sel", {31'd0, s_sel}, 0);
    chk("first_grant_a_ready", {31'd0, s_ar}, 1);
    idle_cycle();

    // A only: 0x11..0x16 back to back.
    obs_dat.delete();
    obs_src.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'h11 + i), 1'b0, 8'h00, 1'b1);
    idle_cycle();
    chk("aonly_count", obs_dat.size(), 6);
    for (int i = 0; i < 6 && i < obs_dat.size(); i++) begin
      chk($sformatf("aonly_data%0d", i), {24'd0, obs_dat[i]}, 32'h11 + i);
      chk($sformatf("aonly_src%0d", i), {31'd0, obs_src[i]}, 0);
    end

    // Fairness: both channels always valid for 12 cycles.
    rst_cycle();
    obs_dat.delete();
    obs_src.delete();
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b1);
    idle_cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{0,0,0,0,0,0,0,0,0,0,0,0};
`else
    exp_seq = '{0,0,0,0,1,1,1,1,0,0,0,0};
`endif
    chk_src_seq("fair", exp_seq);

    // Backpressure: 0x2A held for 3 stalled cycles.
    rst_cycle();
    obs_dat.delete();
    obs_src.delete();
    cycle(1'b0, 1'b1, 8'h2A, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h2B, 1'b0, 8'h00, 1'b0);
      chk($sformatf("bp_hold_data%0d", i), {24'd0, s_yd}, 32'h2A);
      chk($sformatf("bp_hold_valid%0d", i), {31'd0, s_yv}, 1);
      chk($sformatf("bp_a_ready%0d", i), {31'd0, s_ar}, 0);
      chk($sformatf("bp_b_ready%0d", i), {31'd0, s_br}, 0);
    end
    cycle(1'b0, 1'b1, 8'h2B, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b1, 8'h2C, 1'b0, 8'h00, 1'b1);
    idle_cycle();
    chk("bp_count", obs_dat.size(), 3);
    for (int i = 0; i < 3 && i < obs_dat.size(); i++)
      chk($sformatf("bp_data%0d", i), {24'd0, obs_dat[i]}, 32'h2A + i);

    // Early switch: A sends 2 then drops; B then gets a full burst despite A returning.
    rst_cycle();
    obs_dat.delete();
    obs_src.delete();
    cycle(1'b0, 1'b1, 8'h01, 1'b1, 8'h81, 1'b1);
    cycle(1'b0, 1'b1, 8'h02, 1'b1, 8'h82, 1'b1);
    cycle(1'b0, 1'b0, 8'h03, 1'b1, 8'h83, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h04 + i), 1'b1, 8'(8'h84 + i), 1'b1);
    idle_cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{0,0,1,0,0,0,0};
`else
    exp_seq = '{0,0,1,1,1,1,0};
`endif
    chk_src_seq("early", exp_seq);

    // Reset mid-burst: pending word discarded, owner back to A with a fresh burst.
    rst_cycle();
    cycle(1'b0, 1'b1, 8'h31, 1'b1, 8'hC1, 1'b1);
    cycle(1'b0, 1'b1, 8'h32, 1'b1, 8'hC2, 1'b1);
    cycle(1'b1, 1'b1, 8'h33, 1'b1, 8'hC3, 1'b1);
    obs_dat.delete();
    obs_src.delete();
    cycle(1'b0, 1'b1, 8'h34, 1'b1, 8'hC4, 1'b1);
    chk("midrst_y_valid", {31'd0, s_yv}, 0);
    chk("midrst_sel", {31'd0, s_sel}, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'(8'h35 + i), 1'b1, 8'(8'hC5 + i), 1'b1);
    idle_cycle();
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{0,0,0,0,0};
`else
    exp_seq = '{0,0,0,0,1};
`endif
    chk_src_seq("midrst", exp_seq);

    // Randomized traffic with occasional reset and backpressure.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux2_stream_arbiter.md
# mux2_stream_arbiter

Two-input stream arbiter and output register that sits directly upstream of the 2:1 select mux. It accepts two valid/ready data channels (A and B) and decides each cycle which one is granted. It drives the mux `sel` line and captures the selected word into a DFF output stage with its own valid/ready handshake. Arbitration is round-robin with a bounded burst length, so a continuously busy channel cannot starve the other.

## Interface
- `WIDTH`, default 8: data width of both inputs and the output.
- `MAX_BURST`, default 4: maximum consecutive transfers from one channel while the other is waiting. Legal range is 1..15.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `a_data` input WIDTH: channel A data.
- `a_valid` input 1: channel A word present.
- `a_ready` output 1: channel A word accepted this cycle.
- `b_data` input WIDTH: channel B data.
- `b_valid` input 1: channel B word present.
- `b_ready` output 1: channel B word accepted this cycle.
- `sel` output 1: current grant (0 = A, 1 = B). Combinational; drives the mux select.
- `y_data` output WIDTH: registered output word.
- `y_valid` output 1: `y_data` holds a word.
- `y_ready` input 1: downstream accepts `y_data`.
- `y_src` output 1: source channel of the current `y_data` (0 = A, 1 = B).

## Operation
- **State machine**
  - Two states: OWN_A and OWN_B. The state gives the current owner.
  - A burst counter `cnt` (4 bits) counts transfers by the owner in its current burst.
- **Output register enable:** `load_en = !y_valid || y_ready`.
- **Grant `gnt`** (combinational, equal to `sel`):
  - If the owner is valid and (`cnt < MAX_BURST` or the other channel is not valid), `gnt` = owner.
  - Else if the other channel is valid, `gnt` = other.
  - Else `gnt` = owner (no transfer).
- **Ready outputs:**
  - `a_ready = load_en && !gnt && !rst`.
  - `b_ready = load_en && gnt && !rst`.
  - At most one ready is high in any cycle.
- **Transfer** (the granted channel is valid and `load_en` is high):
  - `y_data` ← granted data, `y_src` ← `gnt`, `y_valid` ← 1.
  - If `gnt` == owner: `cnt` ← min(`cnt`+1, `MAX_BURST`).
  - Otherwise: the state switches to `gnt` and `cnt` ← 1.
- **No transfer while `load_en` is high:** `y_valid` ← 0 (the previous word has drained). The state and `cnt` hold.
- **`load_en` low:** `y_data`, `y_src`, `y_valid`, the state and `cnt` all hold. Both readies are 0.
- **Owner goes idle mid-burst:** the other channel takes the grant in the same cycle, and `cnt` restarts at 1.
- **Burst exhausted with the other channel idle:** the owner keeps the grant and `cnt` saturates at `MAX_BURST`.
- **Reset:**
  - State OWN_A, `cnt`=0, `y_valid`=0, `y_data`=0, `y_src`=0.
  - While `rst` is high, `sel`=0 and `a_ready`=`b_ready`=0.
  - A `y` word pending at reset is discarded, not delivered.

## Timing
- Latency: an input handshake at edge N makes `y_valid`=1 with that word after edge N.
- Throughput: one word per cycle while `y_ready` stays high.
- `y_data`/`y_src` stay stable while `y_valid && !y_ready`.
- Within a cycle, `sel` and the readies depend combinationally on `a_valid`, `b_valid` and `y_ready`. No combinational path exists from data to ready.
- `rst` and a transfer in the same cycle: `rst` wins.

## Configuration
- `MUX_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. `gnt` = A whenever `a_valid`, B only when `!a_valid && b_valid`. `MAX_BURST` and `cnt` have no effect on the grant. The state still tracks the last granted channel.
  - Undefined (default): round-robin with burst limit, as described above.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both channels valid → `y_valid`=0, `y_data`=0, `sel`=0, `a_ready`=`b_ready`=0. The first grant after release goes to A.
- **A only:** `a_data` = 0x11..0x16 on consecutive cycles, `y_ready`=1 → `y_data` = 0x11..0x16 one cycle later each, `y_src`=0, no gaps.
- **Fairness** (`MAX_BURST`=4, both channels always valid, `y_ready`=1) → `y_src` sequence A,A,A,A,B,B,B,B,A,A,A,A. `sel` toggles one cycle before the first word of each burst appears.
- **Backpressure:** `y_ready`=0 for 3 cycles while `y_valid`=1 with 0x2A → `y_data` is held at 0x2A and both readies are 0. After release the stream continues with no loss or duplication.
- **Early switch:** A sends 2 words then drops `a_valid` while B is valid → B is granted in the next cycle with `cnt`=1 and gets a full 4-beat burst.
- **Reset mid-burst / fixed priority:**
  - Assert `rst` after 2 A beats with `y_valid`=1 → `y_valid`=0 on the next cycle and the state is OWN_A.
  - With `MUX_ARB_FIXED_PRIO_EN` defined and both channels valid for 10 cycles → all 10 outputs have `y_src`=0.
